onchip_ram_stream_writer: RTL and testbench

//  Avalon-MM write master that drains a valid/ready sample stream into the 64 KB on-chip RAM (16384 x 32-bit).

---
 rtl/onchip_ram_stream_writer.sv | 141 ++++++++++++++
 tb/tb_onchip_ram_stream_writer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_ram_stream_writer.sv
// Avalon-MM write master: drains a valid/ready stream into on-chip RAM, one word register deep.
// Optional ONCHIP_RAM_WRITER_BYTE_PACK_EN packs byte beats little-endian into 32-bit words.
module onchip_ram_stream_writer #(
  parameter int ADDR_W = 14,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  beat_count,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  words_written
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] beats_left;
  logic             out_free, wr_done, fire, flush;
  logic [31:0]      word_nxt;
  logic [3:0]       be_nxt;

  assign out_free = !avm_write || !avm_waitrequest;
  assign wr_done  = avm_write && !avm_waitrequest;
  assign fire     = in_valid && in_ready;

`ifdef ONCHIP_RAM_WRITER_BYTE_PACK_EN
  logic [1:0]  pack_cnt;
  logic [23:0] pack_data;
  logic [31:0] lane_in;
  logic        unused_hi;

  assign unused_hi = ^in_data[31:8];
  assign lane_in   = {24'b0, in_data[7:0]} << {pack_cnt, 3'b000};
  // word goes out once four lanes are filled or the job's last byte arrives
  assign flush     = (pack_cnt == 2'd3) || (beats_left == CNT_W'(1));
  assign word_nxt  = {8'b0, pack_data} | lane_in;

  always_comb begin
    be_nxt = 4'hF;
    case (pack_cnt)
      2'd0:    be_nxt = 4'b0001;
      2'd1:    be_nxt = 4'b0011;
      2'd2:    be_nxt = 4'b0111;
      default: be_nxt = 4'hF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pack_cnt  <= '0;
      pack_data <= '0;
    end else if (state == IDLE && start) begin
      pack_cnt  <= '0;
      pack_data <= '0;
    end else if (fire) begin
      if (flush) begin
        pack_cnt  <= '0;
        pack_data <= '0;
      end else begin
        pack_cnt  <= pack_cnt + 2'd1;
        pack_data <= word_nxt[23:0];
      end
    end
  end
`else
  assign flush    = 1'b1;
  assign word_nxt = in_data;
  assign be_nxt   = 4'hF;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (beat_count == '0) ? DONE : RUN;
      RUN:     if (wr_done && beats_left == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    in_ready = 1'b0;
    case (state)
      RUN: begin
        busy     = 1'b1;
        // a beat that only fills the pack register never needs the output slot
        in_ready = (beats_left != '0) && (out_free || !flush);
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beats_left     <= '0;
      avm_address    <= '0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      avm_byteenable <= '0;
      words_written  <= '0;
    end else begin
      if (state == IDLE && start) begin
        beats_left    <= beat_count;
        avm_address   <= base_addr;
        words_written <= '0;
      end
      if (fire) beats_left <= beats_left - CNT_W'(1);
      if (wr_done) begin
        avm_address <= avm_address + ADDR_W'(1);
        if (words_written != '1) words_written <= words_written + CNT_W'(1);
      end
      if (fire && flush) begin
        avm_write      <= 1'b1;
        avm_writedata  <= word_nxt;
        avm_byteenable <= be_nxt;
      end else if (wr_done) begin
        avm_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_onchip_ram_stream_writer.sv
// Bench for onchip_ram_stream_writer: directed scenarios plus randomized jobs vs a transfer-level model.
module tb_onchip_ram_stream_writer;
  localparam int ADDR_W = 14;
  localparam int CNT_W  = 16;
`ifdef ONCHIP_RAM_WRITER_BYTE_PACK_EN
  localparam bit BYTE_MODE = 1'b1;
`else
  localparam bit BYTE_MODE = 1'b0;
`endif

  logic              clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  beat_count = '0;
  logic [31:0]       in_data = '0;
  logic              in_valid = 1'b0, in_ready;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest = 1'b0;
  logic              busy, done;
  logic [CNT_W-1:0]  words_written;

  onchip_ram_stream_writer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .beat_count(beat_count),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .done(done), .words_written(words_written)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
    logic [3:0]        be;
  } wr_t;

  wr_t         obs[$], exp_q[$];
  int          obs_cyc[$];
  logic [31:0] beats[$];
  int cyc = 0, done_cnt = 0, done_cyc = -1, start_cyc = 0, first_acc_cyc = -1;
  int hold_bad = 0, busy_bad = 0, stall_rdy_bad = 0;
  bit job_end = 1'b0, job_timeout = 1'b0;
  int passed = 0, total = 0;
  wr_t prev;
  bit  prev_stall = 1'b0;

  always @(posedge clk) cyc++;

  // bus monitor: samples mid-cycle, after the drivers have settled this cycle's inputs
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      if (prev_stall && (avm_write !== 1'b1 || wr_t'({avm_address, avm_writedata, avm_byteenable}) !== prev))
        hold_bad++;
      if (avm_write && !avm_waitrequest) begin
        obs.push_back(wr_t'({avm_address, avm_writedata, avm_byteenable}));
        obs_cyc.push_back(cyc);
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (done && busy) busy_bad++;
      prev_stall = avm_write && avm_waitrequest;
      prev = wr_t'({avm_address, avm_writedata, avm_byteenable});
    end else prev_stall = 1'b0;
  end

  // reference: what the RAM should receive for a job of n beats from base
  function automatic void build_exp(input logic [ADDR_W-1:0] base, input int n);
    wr_t w;
    exp_q.delete();
    if (!BYTE_MODE) begin
      for (int i = 0; i < n; i++) begin
        w.a = ADDR_W'(base + i); w.d = beats[i]; w.be = 4'hF;
        exp_q.push_back(w);
      end
    end else begin
      for (int k = 0; k < (n + 3) / 4; k++) begin
        w.a = ADDR_W'(base + k); w.d = '0; w.be = '0;
        for (int j = 0; j < 4; j++)
          if (4 * k + j < n) begin
            w.d[8*j +: 8] = beats[4*k+j][7:0];
            w.be[j] = 1'b1;
          end
        exp_q.push_back(w);
      end
    end
  endfunction

  task automatic feed(input int n, input int gap_pct);
    int i = 0;
    first_acc_cyc = -1;
    while (i < n && !job_end) begin
      @(negedge clk);
      if ($urandom_range(99) >= gap_pct) begin in_valid = 1'b1; in_data = beats[i]; end
      else begin in_valid = 1'b0; in_data = $urandom; end
      #1;
      if (in_valid && in_ready) begin
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        i++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drive_wait(input int stall_pct, input bit stall2, input logic [ADDR_W-1:0] a2);
    int sc = 0;
    while (!job_end) begin
      @(negedge clk);
      if (stall2) begin
        if (avm_write && avm_address == a2 && sc < 3) begin avm_waitrequest = 1'b1; sc++; end
        else avm_waitrequest = 1'b0;
        if (avm_waitrequest) begin #1; if (in_ready !== 1'b0) stall_rdy_bad++; end
      end else avm_waitrequest = ($urandom_range(99) < stall_pct);
    end
    avm_waitrequest = 1'b0;
  endtask

  task automatic run_job(input logic [ADDR_W-1:0] base, input int n, input int gap_pct,
                         input int stall_pct, input bit stall2);
    int d0;
    obs.delete(); obs_cyc.delete();
    hold_bad = 0; busy_bad = 0; stall_rdy_bad = 0; job_end = 1'b0; job_timeout = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    base_addr = base; beat_count = CNT_W'(n); start = 1'b1; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0; base_addr = ADDR_W'($urandom); beat_count = CNT_W'($urandom);
    fork
      feed(n, gap_pct);
      drive_wait(stall_pct, stall2, ADDR_W'(base + 1));
      begin
        int g = 0;
        while (done_cnt == d0 && g < 4000) begin @(negedge clk); g++; end
        if (done_cnt == d0) job_timeout = 1'b1;
        job_end = 1'b1;
      end
    join
    repeat (2) @(negedge clk);
    build_exp(base, n);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; beat_count = 16'd5;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({in_ready, avm_write, avm_address, avm_writedata, avm_byteenable, busy, done, words_written} !== '0)
      $display("FAIL reset_outputs: got addr=%h wr=%b data=%h be=%h busy=%b done=%b ww=%0d rdy=%b, want all 0",
               avm_address, avm_write, avm_writedata, avm_byteenable, busy, done, words_written, in_ready);
    else passed++;
    reset = 1'b0; start = 1'b0; beat_count = '0;
    @(negedge clk); #1;
    total++;
    if ({busy, done, avm_write} !== 3'b000) $display("FAIL reset_release_idle: busy/done/wr=%b want 000", {busy, done, avm_write});
    else passed++;
  endtask

  task automatic test_basic();
    int d0 = done_cnt, bad = 0;
    beats.delete();
    for (int k = 1; k <= 4; k++) beats.push_back(32'h11111111 * k);
    run_job(14'h0010, 4, 0, 0, 1'b0);
    total++; if (job_timeout) $display("FAIL basic_timeout: done not seen"); else passed++;
    total++;
    if (obs.size() != 4) $display("FAIL basic_count: got %0d writes want 4", obs.size()); else passed++;
    for (int i = 0; i < obs.size() && i < 4; i++) begin
      total++;
      if (obs[i] !== exp_q[i]) $display("FAIL basic_write%0d: got %h want %h", i, obs[i], exp_q[i]);
      else passed++;
    end
    if (obs.size() == 4) begin
      total++;
      if (obs_cyc[3] - obs_cyc[0] != 3) $display("FAIL basic_consecutive: span %0d want 3", obs_cyc[3] - obs_cyc[0]);
      else passed++;
      total++;
      if (obs_cyc[0] != first_acc_cyc + 1) $display("FAIL basic_latency: write cyc %0d want %0d", obs_cyc[0], first_acc_cyc + 1);
      else passed++;
      total++;
      if (done_cyc != obs_cyc[3] + 1) $display("FAIL basic_done_timing: done cyc %0d want %0d", done_cyc, obs_cyc[3] + 1);
      else passed++;
    end
    total++;
    if (words_written !== 16'd4) $display("FAIL basic_words_written: got %0d want 4", words_written); else passed++;
    total++;
    if (done_cnt != d0 + 1 || busy_bad != 0) $display("FAIL basic_done_pulse: pulses %0d busy_overlap %0d want 1/0", done_cnt - d0, busy_bad);
    else passed++;
    if (bad != 0) $display("FAIL basic_internal: %0d", bad);
  endtask

  task automatic test_stall();
    int nbad = 0;
    beats.delete();
    for (int k = 1; k <= 4; k++) beats.push_back(32'h11111111 * k);
    run_job(14'h0010, 4, 0, 0, 1'b1);
    total++;
    if (obs.size() != 4 || job_timeout) $display("FAIL stall_count: got %0d writes (timeout=%0d) want 4", obs.size(), job_timeout);
    else passed++;
    for (int i = 0; i < obs.size() && i < 4; i++) if (obs[i] !== exp_q[i]) nbad++;
    total++; if (nbad != 0) $display("FAIL stall_writes: %0d wrong writes want 0", nbad); else passed++;
    total++; if (hold_bad != 0) $display("FAIL stall_hold: %0d unstable cycles want 0", hold_bad); else passed++;
    total++; if (stall_rdy_bad != 0) $display("FAIL stall_in_ready: high in %0d stall cycles want 0", stall_rdy_bad); else passed++;
    if (obs.size() == 4) begin
      total++;
      if (obs_cyc[1] - obs_cyc[0] != 4) $display("FAIL stall_duration: gap %0d want 4", obs_cyc[1] - obs_cyc[0]);
      else passed++;
    end
    total++; if (words_written !== 16'd4) $display("FAIL stall_words_written: got %0d want 4", words_written); else passed++;
  endtask

  task automatic test_wrap();
    int nbad = 0;
    beats.delete();
    for (int k = 0; k < 4; k++) beats.push_back($urandom);
    run_job(14'h3FFE, 4, 20, 20, 1'b0);
    total++;
    if (obs.size() != exp_q.size() || job_timeout) $display("FAIL wrap_count: got %0d want %0d", obs.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) if (obs[i] !== exp_q[i]) nbad++;
    total++; if (nbad != 0) $display("FAIL wrap_writes: %0d wrong want 0", nbad); else passed++;
    if (!BYTE_MODE && obs.size() == 4) begin
      total++;
      if (obs[2].a !== 14'h0000 || obs[3].a !== 14'h0001) $display("FAIL wrap_addr: got %h %h want 0000 0001", obs[2].a, obs[3].a);
      else passed++;
    end
  endtask

  task automatic test_zero();
    beats.delete();
    run_job(14'h0123, 0, 0, 0, 1'b0);
    total++; if (obs.size() != 0) $display("FAIL zero_writes: got %0d want 0", obs.size()); else passed++;
    total++;
    if (done_cyc != start_cyc + 1 || job_timeout) $display("FAIL zero_done_timing: done cyc %0d want %0d", done_cyc, start_cyc + 1);
    else passed++;
    total++; if (words_written !== 16'd0) $display("FAIL zero_words_written: got %0d want 0", words_written); else passed++;
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++) begin
      int n = $urandom_range(40, 1), nbad = 0;
      logic [ADDR_W-1:0] b = ADDR_W'($urandom);
      beats.delete();
      for (int k = 0; k < n; k++) beats.push_back($urandom);
      run_job(b, n, $urandom_range(50), $urandom_range(50), 1'b0);
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) if (obs[i] !== exp_q[i]) nbad++;
      total++;
      if (job_timeout || obs.size() != exp_q.size() || nbad != 0)
        $display("FAIL random%0d_writes: got %0d writes (%0d wrong, timeout=%0d) want %0d", j, obs.size(), nbad, job_timeout, exp_q.size());
      else passed++;
      total++;
      if (words_written !== CNT_W'(exp_q.size())) $display("FAIL random%0d_words_written: got %0d want %0d", j, words_written, exp_q.size());
      else passed++;
      total++;
      if (hold_bad != 0 || busy_bad != 0) $display("FAIL random%0d_hold: unstable %0d busy_overlap %0d want 0", j, hold_bad, busy_bad);
      else passed++;
      if (obs.size() > 0) begin
        total++;
        if (done_cyc != obs_cyc[obs.size()-1] + 1) $display("FAIL random%0d_done_timing: %0d want %0d", j, done_cyc, obs_cyc[obs.size()-1] + 1);
        else passed++;
      end
    end
  endtask

`ifdef ONCHIP_RAM_WRITER_BYTE_PACK_EN
  task automatic test_byte_pack();
    beats.delete();
    for (int k = 0; k < 6; k++) beats.push_back({$urandom_range(255, 0) << 8, 8'hA0 + 8'(k)} & 32'h0000FFFF);
    run_job(14'h0200, 6, 0, 0, 1'b0);
    total++;
    if (obs.size() != 2 || job_timeout) $display("FAIL byte_count: got %0d writes want 2", obs.size()); else passed++;
    if (obs.size() == 2) begin
      total++;
      if (obs[0].d !== 32'hA3A2A1A0 || obs[0].be !== 4'hF) $display("FAIL byte_word0: got %h be=%b want a3a2a1a0 be=1111", obs[0].d, obs[0].be);
      else passed++;
      total++;
      if (obs[1].d !== 32'h0000A5A4 || obs[1].be !== 4'b0011) $display("FAIL byte_word1: got %h be=%b want 0000a5a4 be=0011", obs[1].d, obs[1].be);
      else passed++;
    end
    total++; if (words_written !== 16'd2) $display("FAIL byte_words_written: got %0d want 2", words_written); else passed++;
  endtask
`endif

  task automatic test_reset_mid();
    int g = 0, nbad = 0;
    obs.delete(); obs_cyc.delete();
    @(negedge clk);
    base_addr = '0; beat_count = CNT_W'(BYTE_MODE ? 32 : 8); start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; avm_waitrequest = 1'b0;
    while (obs.size() < 2 && g < 100) begin @(negedge clk); #3; g++; end
    total++; if (g >= 100) $display("FAIL rstmid_progress: only %0d writes seen want 2", obs.size()); else passed++;
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk); #1;
    total++;
    if ({in_ready, avm_write, avm_address, avm_writedata, avm_byteenable, busy, done, words_written} !== '0)
      $display("FAIL rstmid_outputs: wr=%b addr=%h busy=%b ww=%0d rdy=%b want all 0", avm_write, avm_address, busy, words_written, in_ready);
    else passed++;
    @(negedge clk); reset = 1'b0;
    beats.delete(); beats.push_back($urandom);
    run_job(14'h0000, 1, 0, 0, 1'b0);
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) if (obs[i] !== exp_q[i]) nbad++;
    total++;
    if (job_timeout || obs.size() != 1 || nbad != 0) $display("FAIL rstmid_restart: got %0d writes (%0d wrong) want 1", obs.size(), nbad);
    else passed++;
    total++; if (words_written !== 16'd1) $display("FAIL rstmid_words_written: got %0d want 1", words_written); else passed++;
  endtask

  initial begin
    test_reset();
`ifndef ONCHIP_RAM_WRITER_BYTE_PACK_EN
    test_basic();
    test_stall();
`else
    test_byte_pack();
`endif
    test_wrap();
    test_zero();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
